// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder : boot-loaded dual-read / single-write word memory for a CPU |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_responder #(
  parameter int ADDR_W = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] im_addr,
  input  logic [3:0]  im_w_en,
  output logic [31:0] im_rdata,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_w_en,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_rst,
  output logic        boot_done,
  output logic        err_oob,
  output logic        err_im_wr
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [31:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic              ld_ready_q, ld_ready_d;
  logic [31:0]       im_rdata_q, im_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              err_oob_q, err_oob_d;
  logic              err_im_wr_q, err_im_wr_d;

  logic [ADDR_W-1:0] im_idx, dm_idx;
  logic              im_oob, dm_oob;
  logic              in_run, ld_fire, load_at_end;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;

  // Byte offset bits never select a word; they are deliberately dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{im_addr[1:0], dm_addr[1:0]};

  assign im_idx      = im_addr[ADDR_W+1:2];
  assign dm_idx      = dm_addr[ADDR_W+1:2];
  assign im_oob      = |im_addr[31:ADDR_W+2];
  assign dm_oob      = |dm_addr[31:ADDR_W+2];
  assign in_run      = (state_q == ST_RUN);
  assign ld_fire     = (state_q == ST_LOAD) && ld_ready_q && ld_valid;
  assign load_at_end = &load_cnt_q;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (ld_fire) begin
          if (!load_at_end) begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
          if (ld_last || load_at_end) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = ST_LOAD;
    endcase
  end

  // Ready is registered so it stays low for the whole reset and rises on the first edge after.
  assign ld_ready_d = (state_d == ST_LOAD);

  // Single write port: loader owns it while loading, the data port while running.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = dm_idx;
    wr_data = dm_wdata;
    wr_be   = dm_w_en;
    if (ld_fire) begin
      wr_en   = 1'b1;
      wr_idx  = load_cnt_q;
      wr_data = ld_data;
      wr_be   = 4'hF;
    end else if (in_run && (dm_w_en != 4'h0) && !dm_oob) begin
      wr_en = 1'b1;
    end
  end

  always_comb begin
    im_rdata_d  = 32'h0;
    dm_rdata_d  = 32'h0;
    err_oob_d   = err_oob_q;
    err_im_wr_d = err_im_wr_q;
    if (in_run) begin
      if (!im_oob) begin
        im_rdata_d = mem[im_idx];
      end
      if (!dm_oob) begin
        dm_rdata_d = mem[dm_idx];
      end else begin
        err_oob_d = 1'b1;
      end
      if (im_w_en != 4'h0) begin
        err_im_wr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      ld_ready_q  <= 1'b0;
      im_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
      err_oob_q   <= 1'b0;
      err_im_wr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      ld_ready_q  <= ld_ready_d;
      im_rdata_q  <= im_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_oob_q   <= err_oob_d;
      err_im_wr_q <= err_im_wr_d;
    end
  end

  // Storage is never reset so an image survives a CPU-side reset; reads above are read-first.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign im_rdata  = im_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign ld_ready  = ld_ready_q;
  assign cpu_rst   = in_run;
  assign boot_done = in_run;
  assign err_oob   = err_oob_q;
  assign err_im_wr = err_im_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_responder : directed self-checking bench for mem_responder          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr;
  logic [3:0]  im_w_en;
  logic [31:0] im_rdata;
  logic [31:0] dm_addr;
  logic [3:0]  dm_w_en;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_rst;
  logic        boot_done;
  logic        err_oob;
  logic        err_im_wr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  mem_responder #(.ADDR_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .im_addr   (im_addr),
    .im_w_en   (im_w_en),
    .im_rdata  (im_rdata),
    .dm_addr   (dm_addr),
    .dm_w_en   (dm_w_en),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_rst   (cpu_rst),
    .boot_done (boot_done),
    .err_oob   (err_oob),
    .err_im_wr (err_im_wr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {ld_ready, cpu_rst, boot_done, err_oob, err_im_wr}
  function automatic logic [31:0] flags();
    return {27'h0, ld_ready, cpu_rst, boot_done, err_oob, err_im_wr};
  endfunction

  function automatic logic [31:0] img(input int i);
    return 32'hA500_0000 | i;
  endfunction

  initial begin
    rst = 1'b0; im_addr = '0; im_w_en = '0; dm_addr = '0; dm_w_en = '0;
    dm_wdata = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_flags", flags(), 32'h0);
    check("rst_im_rdata", im_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);

    rst = 1'b1;
    tick();
    check("ld_ready_after_rst", flags(), 32'h10);

    // Three-beat boot image; data port activity during load must be ignored
    ld_valid = 1'b1; ld_data = 32'h0000_0013;
    tick();
    ld_data = 32'h0010_0093;
    tick();
    check("load_im_rdata_zero", im_rdata, 32'h0);
    ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
    dm_addr = 32'h4; dm_w_en = 4'hF; dm_wdata = 32'hBADB_AD00;
    tick();
    check("release_flags", flags(), 32'h00);
    check("load_dm_rdata_zero", dm_rdata, 32'h0);
    ld_valid = 1'b0; ld_last = 1'b0; dm_w_en = 4'h0;
    tick();
    check("run_flags", flags(), 32'h0C);
    im_addr = 32'h8;
    tick();
    check("im_read_word2", im_rdata, 32'hDEAD_BEEF);
    check("dm_write_ignored_in_load", dm_rdata, 32'h0010_0093);

    // Out-of-range fetch returns zero and raises nothing
    im_addr = 32'h0001_0008;
    tick();
    check("im_oob_zero", im_rdata, 32'h0);
    check("im_oob_no_flag", flags(), 32'h0C);

    // Byte-lane store
    dm_addr = 32'h10; dm_w_en = 4'hF; dm_wdata = 32'h1122_3344;
    tick();
    dm_w_en = 4'b0100; dm_wdata = 32'h00AA_0000;
    tick();
    check("byte_store_read_first", dm_rdata, 32'h1122_3344);
    dm_w_en = 4'h0;
    tick();
    check("byte_store_merge", dm_rdata, 32'h11AA_3344);

    // Read-during-write on both ports
    dm_addr = 32'h20; dm_w_en = 4'hF; dm_wdata = 32'h0;
    tick();
    dm_wdata = 32'hCAFE_F00D; im_addr = 32'h20;
    tick();
    check("rdw_dm_old", dm_rdata, 32'h0);
    check("rdw_im_old", im_rdata, 32'h0);
    dm_w_en = 4'h0;
    tick();
    check("rdw_dm_new", dm_rdata, 32'hCAFE_F00D);
    check("rdw_im_new", im_rdata, 32'hCAFE_F00D);

    // Out-of-range data store is suppressed and flagged stickily
    dm_addr = 32'h0001_0000; dm_w_en = 4'hF; dm_wdata = 32'h1234_5678; im_addr = 32'h0;
    tick();
    check("dm_oob_rdata", dm_rdata, 32'h0);
    check("dm_oob_flag", flags(), 32'h0E);
    dm_addr = 32'h10; dm_w_en = 4'h0;
    tick();
    check("dm_oob_no_write", im_rdata, 32'h0000_0013);
    check("dm_oob_sticky", flags(), 32'h0E);
    check("dm_after_oob", dm_rdata, 32'h11AA_3344);

    // Instruction-port write attempt; ld_valid also ignored in RUN
    im_w_en = 4'h1; im_addr = 32'h8; ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
    tick();
    im_w_en = 4'h0;
    tick();
    check("im_wr_flag", flags(), 32'h0F);
    check("im_wr_no_write", im_rdata, 32'hDEAD_BEEF);
    ld_valid = 1'b0;

    // Asynchronous reset from RUN
    rst = 1'b0;
    #1;
    check("async_rst_flags", flags(), 32'h0);
    check("async_rst_rdata", im_rdata | dm_rdata, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("reload_ready", flags(), 32'h10);

    // Beats with gaps, then abort after two beats
    ld_valid = 1'b1; ld_data = 32'h1111_0000;
    tick();
    ld_valid = 1'b0; ld_data = 32'hBAD0_BAD0;
    tick();
    ld_valid = 1'b1; ld_data = 32'h1111_0001;
    tick();
    ld_valid = 1'b0; ld_data = 32'hBAD1_BAD1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_flags", flags(), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    ld_valid = 1'b1; ld_data = 32'h2222_0000; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    check("short_load_run", flags(), 32'h0C);
    im_addr = 32'h0; dm_addr = 32'h4;
    tick();
    check("restart_word0", im_rdata, 32'h2222_0000);
    check("gap_retained_word1", dm_rdata, 32'h1111_0001);
    im_addr = 32'h8; dm_addr = 32'h10;
    tick();
    check("retained_word2", im_rdata, 32'hDEAD_BEEF);
    check("retained_word4", dm_rdata, 32'h11AA_3344);

    // Full image without ld_last
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16384; i++) begin
      ld_valid = 1'b1; ld_data = img(i);
      tick();
      if (i == 16382) check("full_before_last", flags(), 32'h10);
    end
    ld_data = 32'hFFFF_FFFF;
    check("full_release", flags(), 32'h00);
    tick();
    check("full_run", flags(), 32'h0C);
    tick();
    ld_valid = 1'b0;
    im_addr = 32'hFFFC; dm_addr = 32'h0;
    tick();
    check("full_last_word", im_rdata, img(16383));
    check("full_first_word", dm_rdata, img(0));
    im_addr = 32'h20;
    tick();
    check("full_word8", im_rdata, img(8));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
